clk_div_arbiter: RTL
====================

Name: clk_div_arbiter

Overview:
Round-robin scheduler that shares one clk_div instance among NREQ requesters (e.g. sniffer UART TX, SPI config engine).
- Each requester asks for a burst of N divided-clock pulses.
- The arbiter grants one requester at a time and drives the divider's enable.
- It forwards the divider's pulses to the winner, counts them, and signals completion.
- Between grants it holds the divider disabled so every burst starts from the divider's preset phase.

Parameters:
NREQ, 2, number of requesters (≥2).
CNT_W, 8, width of each burst-length field and of the pulse counter.
IDLE_GAP, 2, clk_in cycles the divider is held disabled after a burst ends (0 allowed).

Ports:
clk_in  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
req  input  NREQ  per-requester request level; held until done, dropping it aborts.
len  input  NREQ*CNT_W  burst lengths; requester i uses bits [i*CNT_W +: CNT_W]; sampled at grant.
grant  output  NREQ  one-hot grant, registered.
done  output  NREQ  one-cycle completion strobe to the winner, registered.
tick  output  NREQ  div_pulse routed to the granted requester only.
busy  output  1  high whenever state is not IDLE.
div_enable  output  1  drives clk_div enable, registered.
div_pulse  input  1  clk_div clk_pulse.

Behaviour:
- Reset (sync): state=IDLE; grant=0, done=0, div_enable=0, busy=0, remaining=0, last winner=NREQ-1, so req[0] wins first.
- States: IDLE, RUN, GAP.
- IDLE:
  - If req≠0, pick the first set bit searching from (last+1) mod NREQ, wrapping.
  - Next edge: grant=onehot(winner), remaining=len[winner], last=winner, div_enable=1, state=RUN.
  - Zero-length case: if len[winner]==0, go to GAP instead. At that edge grant=onehot(winner) for one cycle, div_enable stays 0, and done[winner] pulses on the next edge together with grant clearing.
- RUN:
  - tick[i] = div_pulse & grant[i], combinational, zero latency.
  - Each div_pulse decrements remaining.
  - On the div_pulse that takes remaining 1→0, the next edge sets done[winner]=1 for one cycle, grant=0, div_enable=0, state=GAP.
- Abort: if req[winner] is low in any RUN cycle, the next edge sets grant=0, div_enable=0, state=GAP, with no done.
  - If abort and final pulse coincide, completion wins: done is asserted.
  - A div_pulse in the abort cycle is still forwarded on tick.
- GAP:
  - div_enable=0 for IDLE_GAP cycles, which reloads clk_div's preset. Then IDLE.
  - With IDLE_GAP=0, the next edge goes to IDLE.
  - Requests are not evaluated in GAP.
- Divider phase contract: with clk_div preset 0b01..1, the first div_pulse arrives 1 cycle after div_enable rises. Later pulses arrive every 2^DIVIDER cycles.
  - Grant-to-done latency = 1 + (len-1)·2^DIVIDER + 1 cycles.
- Changes to len during RUN are ignored.
- Requests from non-winners are held pending, never lost.
- div_pulse outside RUN is ignored and not forwarded.
- rst asserted mid-RUN: all outputs 0 on the next edge; no done.
- Invariants: grant is zero or one-hot; done is only asserted the cycle after a grant ends; div_enable=1 only in RUN.

Test Plan:
- Single burst (DIVIDER=3, req0=1, len0=3) -> grant0 asserts 1 cycle after req. Ticks arrive at grant+1, +9, +17. done0 is one cycle at +18, div_enable drops the same cycle, busy clears 2 cycles later.
- Contention (req0=req1=1 from reset, len=2 each) -> req0 served first, then req1 after GAP. Re-raising req0 while req1 runs leaves it pending; it is served next. Grants alternate 0,1,0.
- Abort (req1 dropped after first tick, len1=5) -> grant1 clears next edge, no done1, div_enable=0 for exactly IDLE_GAP cycles, arbiter returns to IDLE.
- Zero length (len0=0) -> one-cycle grant0, no tick, done0 the following cycle, div_enable never asserted.
- Coincident final tick and req drop -> done asserted.
- Mid-burst reset -> all outputs 0, no done; the next grant goes to req0.
- Max length (len=255, DIVIDER=1) -> exactly 255 ticks, then done.

Source files
------------

// File: rtl/clk_div_arbiter.sv
// clk_div_arbiter
//   Round-robin scheduler that shares one clk_div among NREQ requesters.
//   Each requester asks for a burst of divided-clock pulses. The arbiter
//   grants one requester at a time, enables the divider, forwards its
//   pulses to the winner, counts them and strobes done on completion.
//   Between bursts the divider is held disabled so every burst starts
//   from the divider's preset phase.
//
// Ports
//   clk_in     : system clock, all logic on posedge
//   rst        : synchronous active-high reset
//   req        : per-requester request level, dropping it aborts a burst
//   len        : burst lengths, requester i uses len[i*CNT_W +: CNT_W]
//   grant      : registered one-hot grant
//   done       : registered one-cycle completion strobe to the winner
//   tick       : div_pulse routed to the granted requester (RUN only)
//   busy       : high whenever the arbiter is not idle
//   div_enable : registered enable for the shared clk_div
//   div_pulse  : pulse output of the shared clk_div
//
// state | meaning
// IDLE  | divider disabled, choosing the next requester
// RUN   | divider enabled, pulses forwarded to and counted for the winner
// GAP   | divider held disabled to reload its preset before the next grant

module clk_div_arbiter #(
  parameter int NREQ     = 2,
  parameter int CNT_W    = 8,
  parameter int IDLE_GAP = 2
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       tick,
  output logic                  busy,
  output logic                  div_enable,
  input  logic                  div_pulse
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GAP_W = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IDLE_GAP);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } state_t;

  state_t           state_q;
  logic [NREQ-1:0]  grant_q;
  logic [NREQ-1:0]  done_q;
  logic             div_en_q;
  logic [CNT_W-1:0] rem_q;
  logic [IDX_W-1:0] last_q;
  logic [GAP_W-1:0] gap_q;

  logic             win_found;
  logic [IDX_W-1:0] last_d;
  logic [NREQ-1:0]  grant_d;
  logic [CNT_W-1:0] rem_d;
  logic             final_pulse;

  // Round-robin search starting just after the previous winner, wrapping.
  always_comb begin
    int cand;
    win_found = 1'b0;
    last_d    = last_q;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        last_d    = cand[IDX_W-1:0];
      end
    end
    grant_d         = '0;
    grant_d[last_d] = win_found;
    rem_d           = len[last_d*CNT_W +: CNT_W];
  end

  assign final_pulse = div_pulse && (rem_q == REM_ONE);

  assign grant      = grant_q;
  assign done       = done_q;
  assign div_enable = div_en_q;
  assign busy       = (state_q != S_IDLE);
  // Zero-latency forward; pulses outside RUN (e.g. the zero-length grant
  // cycle in GAP) are not routed.
  assign tick       = (state_q == S_RUN && div_pulse) ? grant_q : '0;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      div_en_q <= 1'b0;
      rem_q    <= '0;
      last_q   <= LAST_RST;
      gap_q    <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            grant_q <= grant_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            if (rem_d == '0) begin
              // Zero-length burst: grant for one cycle, done in GAP.
              state_q <= S_GAP;
              gap_q   <= GAP_LOAD;
            end else begin
              div_en_q <= 1'b1;
              state_q  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (div_pulse) rem_q <= rem_q - REM_ONE;
          // Completion has priority over an abort in the same cycle.
          if (final_pulse || !req[last_q]) begin
            done_q   <= final_pulse ? grant_q : '0;
            grant_q  <= '0;
            div_en_q <= 1'b0;
            state_q  <= S_GAP;
            gap_q    <= GAP_LOAD;
          end
        end
        S_GAP: begin
          if (grant_q != '0) begin
            done_q  <= grant_q;
            grant_q <= '0;
          end
          // GAP always lasts at least one cycle, even with IDLE_GAP = 0.
          if (gap_q <= GAP_ONE) state_q <= S_IDLE;
          else                  gap_q   <= gap_q - GAP_ONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
